asym_width_fifo: RTL and testbench
==================================

# asym_width_fifo

Single-clock asymmetric-width FIFO: narrow write stream in, wide read stream out, parametrised in narrow width, width ratio and depth. It is the synthesizable, handshaked successor to the NDP narrow-write/wide-read buffer. Narrow words are packed into wide words, stored, and drained with valid/ready flow control. It sits between the NDP input staging path and the wide compute-lane consumers.

## Interface
- `W_WIDTH`, default 32: narrow write word width in bits.
- `RATIO`, default 2: narrow lanes per wide word. Must be ≥2.
- `DEPTH`, default 8: wide-word storage entries. Must be a power of two, ≥2.
- `R_WIDTH`, derived, W_WIDTH*RATIO: wide read width. Localparam.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `wr_valid`, in, 1: narrow word offered.
- `wr_ready`, out, 1: narrow word accepted when high with `wr_valid`.
- `wr_data`, in, W_WIDTH: narrow word.
- `wr_last`, in, 1: flush marker. Only effective with `ASYM_FIFO_FLUSH_EN`.
- `rd_valid`, out, 1: wide word present on `rd_data`.
- `rd_ready`, in, 1: consumer takes the word when high with `rd_valid`.
- `rd_data`, out, R_WIDTH: wide word. Lane 0 is in the LSBs.
- `count`, out, $clog2(DEPTH+1): wide words held, counting storage plus the output register.

## Operation
- Write side: a lane counter runs 0..RATIO-1. Each accepted narrow word goes into assembly lane `lane`, at bits [lane*W_WIDTH +: W_WIDTH].
- Accepting lane RATIO-1 commits the assembled word into storage at the write pointer. The write pointer increments and the lane counter returns to 0.
- The first narrow word accepted lands in the LSBs of the wide word.
- `wr_ready` = (count != DEPTH). It is registered-derived, with no combinational path from `rd_ready`. Partial assembly is not counted.
- Read side: first-word-fall-through through one output register. Read FSM states:
  - OUT_EMPTY: the output register is loaded when storage is non-empty. Go to OUT_VALID.
  - OUT_VALID: on pop (`rd_valid && rd_ready`), reload from storage if non-empty and stay. Otherwise go to OUT_EMPTY.
- `rd_data` holds stable while `rd_valid && !rd_ready`.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `count` update per cycle: +1 on commit, -1 on pop, unchanged when both occur in the same cycle.
- Reset mid-operation: the partial assembly is discarded, pointers and count are cleared, and `rd_valid` drops immediately. Storage contents are not cleared and are don't-care.

## Timing
- Reset values:
  - `wr_ready`=1, `rd_valid`=0, `rd_data`=0, `count`=0.
  - Lane counter, pointers and FSM are cleared. The FSM resets to OUT_EMPTY.
- Commit on edge E into an empty FIFO: `rd_valid` is high after edge E+1, and `count`=1 after edge E.
- Sustained read throughput: 1 wide word per cycle while `rd_ready` is held high and storage is non-empty.
- Write throughput: 1 narrow word per cycle while `count` < DEPTH.
- Full with a pop at edge E: `wr_ready` returns high after edge E.
- A commit and a pop in the same cycle while full cannot occur, because `wr_ready`=0 when full.

## Configuration
- `ASYM_FIFO_FLUSH_EN` defined:
  - A narrow word accepted with `wr_last`=1 commits the current assembly immediately.
  - Lanes above the current lane are zero-filled, and the lane counter returns to 0.
  - `wr_last` on lane RATIO-1 behaves as a normal commit.
- `ASYM_FIFO_FLUSH_EN` undefined:
  - `wr_last` is ignored. The port stays present and is tied off in the integration.
  - Only full wide words are ever committed.

## Structure
- Shared package `ndp_buf_pkg` holds:
  - the read FSM state enum (OUT_EMPTY, OUT_VALID);
  - a `clog2`-based width helper for pointer and count widths.
- One natural sub-module, `asym_fifo_mem`: a simple dual-port, single-clock R_WIDTH × DEPTH array with a registered write and a combinational read address.
- Lane assembly, pointers, count and the FSM stay in the top module.

## Test plan
- Default parameters. Write 0x11111111 then 0x22222222 → after 2 more edges `rd_valid`=1, `rd_data`=0x22222222_11111111, `count`=1.
- Write 16 narrow words 1..16 with `rd_ready`=0 → `count`=8, `wr_ready`=0. A 17th word is held off. Then drain with `rd_ready`=1: 8 consecutive cycles of data {2,1},{4,3}…{16,15}, then `rd_valid`=0.
- Continuous wrap: stream 64 narrow words with `rd_ready`=1 throughout → 32 wide words out in order, no gaps after the first, and `count` ≤2.
- Simultaneous events: with count=3, commit and pop in the same cycle → `count` stays 3, and the data order is preserved.
- `ASYM_FIFO_FLUSH_EN`, RATIO=4: write 0xA, then 0xB with `wr_last`=1 → `rd_data`=0x00000000_00000000_0000000B_0000000A. The next write lands in lane 0.
- Assert `rst` after 3 narrow writes (one full word and one partial) → `rd_valid`=0 and `count`=0 immediately. After release, 2 new writes produce exactly one correct wide word with no stale lane.

Source files
------------

// File: rtl/ndp_buf_pkg.sv
// Shared definitions for the NDP buffer family.
//   rd_state_e : read-side output register state (OUT_EMPTY, OUT_VALID)
//   clog2_w()  : ceil(log2(n)), never below 1, for pointer/count/lane widths
package ndp_buf_pkg;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } rd_state_e;

  function automatic int clog2_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/asym_fifo_mem.sv
// Simple dual-port single-clock storage array for asym_width_fifo.
// Registered write, combinational read address. Contents are not reset.
// Ports:
//   clk      : clock, rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data (WIDTH bits)
//   i_raddr  : read address
//   o_rdata  : read data, combinational from i_raddr
module asym_fifo_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/asym_width_fifo.sv
// Single-clock asymmetric-width FIFO: narrow words are packed into wide words
// (first accepted word in lane 0 / LSBs), stored, and drained through a
// first-word-fall-through output register with valid/ready handshaking.
//
// Optional feature macro: ASYM_FIFO_FLUSH_EN
//   defined   : wr_last on an accepted word commits the partial assembly,
//               upper lanes zero-filled
//   undefined : wr_last ignored, only complete wide words are committed
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   wr_valid : narrow word offered
//   wr_ready : narrow word accepted (count != DEPTH)
//   wr_data  : narrow word, W_WIDTH bits
//   wr_last  : flush marker (only effective with ASYM_FIFO_FLUSH_EN)
//   rd_valid : wide word present on rd_data
//   rd_ready : consumer takes the word
//   rd_data  : wide word, W_WIDTH*RATIO bits, lane 0 in LSBs
//   count    : wide words held (storage plus output register)
//
// Read FSM:
//   state     | meaning
//   OUT_EMPTY | output register holds nothing; load when storage non-empty
//   OUT_VALID | output register holds a word; reload on pop if storage non-empty
module asym_width_fifo
  import ndp_buf_pkg::*;
#(
  parameter int W_WIDTH = 32,
  parameter int RATIO   = 2,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [W_WIDTH-1:0]           wr_data,
  input  logic                         wr_last,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [W_WIDTH*RATIO-1:0]     rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int R_WIDTH = W_WIDTH * RATIO;
  localparam int PW      = clog2_w(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int LW      = clog2_w(RATIO);

  rd_state_e          r_state, w_state_nxt;
  logic [LW-1:0]      r_lane;
  logic [R_WIDTH-1:0] r_asm, w_asm_word;
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [CW-1:0]      r_count;
  logic [R_WIDTH-1:0] r_rd_data, w_mem_rdata;
  logic               w_wr_fire, w_last_lane, w_commit;
  logic               w_pop, w_rd_valid, w_store_ne, w_load;

  assign wr_ready   = (r_count != CW'(DEPTH));
  assign w_rd_valid = (r_state == OUT_VALID);
  assign rd_valid   = w_rd_valid;
  assign rd_data    = r_rd_data;
  assign count      = r_count;

  assign w_wr_fire   = wr_valid && wr_ready;
  assign w_last_lane = (r_lane == LW'(RATIO - 1));
  assign w_pop       = w_rd_valid && rd_ready;

`ifdef ASYM_FIFO_FLUSH_EN
  assign w_commit = w_wr_fire && (w_last_lane || wr_last);
`else
  logic w_unused_last;
  assign w_unused_last = wr_last;
  assign w_commit      = w_wr_fire && w_last_lane;
`endif

  // Storage occupancy is count minus the word parked in the output register.
  assign w_store_ne = w_rd_valid ? (r_count > CW'(1)) : (r_count != '0);
  assign w_load     = w_store_ne && (!w_rd_valid || w_pop);

  // r_asm only ever holds lanes below r_lane and is cleared on each commit,
  // so a flushed word has its upper lanes zero without extra masking.
  always_comb begin
    w_asm_word = r_asm;
    for (int i = 0; i < RATIO; i++) begin
      if (r_lane == LW'(i)) w_asm_word[i*W_WIDTH +: W_WIDTH] = wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_store_ne)           w_state_nxt = OUT_VALID;
      OUT_VALID: if (w_pop && !w_store_ne) w_state_nxt = OUT_EMPTY;
      default:                             w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_asm  <= '0;
      r_wptr <= '0;
    end else if (w_commit) begin
      r_lane <= '0;
      r_asm  <= '0;
      r_wptr <= r_wptr + PW'(1);
    end else if (w_wr_fire) begin
      r_lane <= r_lane + LW'(1);
      r_asm  <= w_asm_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= OUT_EMPTY;
      r_rptr    <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_rd_data <= w_mem_rdata;
        r_rptr    <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_commit, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  asym_fifo_mem #(
    .WIDTH (R_WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_commit),
    .i_waddr (r_wptr),
    .i_wdata (w_asm_word),
    .i_raddr (r_rptr),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_asym_width_fifo.sv
module tb_asym_width_fifo;

  localparam int W     = 32;
  localparam int RATIO = 2;
  localparam int DEPTH = 8;
  localparam int RW    = W * RATIO;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 0;
  logic          rst = 1;
  logic          wr_valid = 0;
  logic          wr_ready;
  logic [W-1:0]  wr_data = '0;
  logic          wr_last = 0;
  logic          rd_valid;
  logic          rd_ready = 0;
  logic [RW-1:0] rd_data;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  asym_width_fifo #(.W_WIDTH(W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count)
  );

  always #5 clk = ~clk;

  // Behavioural model: queue of committed wide words with their commit edge.
  // A word becomes visible at the head on any edge after the one that committed it.
  typedef struct { logic [RW-1:0] d; int t; } ent_t;
  ent_t          q[$];
  logic [RW-1:0] m_asm = '0;
  int            m_lane = 0;
  int            m_edge = 0;
  int            m_pops = 0;

  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].t < m_edge);
  endfunction

  function automatic bit exp_ready();
    return q.size() != DEPTH;
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_asm  = '0;
      m_lane = 0;
    end else begin
      bit pop, acc, last;
      pop  = exp_valid() && rd_ready;
      acc  = wr_valid && exp_ready();
      m_edge++;
      if (pop) begin
        void'(q.pop_front());
        m_pops++;
      end
      if (acc) begin
        m_asm[m_lane*W +: W] = wr_data;
`ifdef ASYM_FIFO_FLUSH_EN
        last = (m_lane == RATIO - 1) || wr_last;
`else
        last = (m_lane == RATIO - 1);
`endif
        if (last) begin
          ent_t e;
          e.d = m_asm;
          e.t = m_edge;
          q.push_back(e);
          m_asm  = '0;
          m_lane = 0;
        end else begin
          m_lane++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_count", RW'(count), '0);
      chk("rst_rd_valid", RW'(rd_valid), '0);
      chk("rst_wr_ready", RW'(wr_ready), RW'(1));
      chk("rst_rd_data", rd_data, '0);
    end else begin
      chk("count", RW'(count), RW'(q.size()));
      chk("wr_ready", RW'(wr_ready), RW'(exp_ready()));
      chk("rd_valid", RW'(rd_valid), RW'(exp_valid()));
      if (exp_valid()) chk("rd_data", rd_data, q[0].d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] d, input logic last);
    wr_valid = 1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 0;
    wr_last  = 0;
  endtask

  task automatic drain();
    wr_valid = 0;
    rd_ready = 1;
    repeat (2 * DEPTH + 4) tick();
    rd_ready = 0;
  endtask

  initial begin
    int maxc;
    int pops0;
    repeat (2) tick();
    rst = 0;
    tick();

    // Two narrow words form one wide word, lane 0 in the LSBs.
    wr(32'h11111111, 0);
    wr(32'h22222222, 0);
    tick();
    tick();
    chk("t1_rd_valid", RW'(rd_valid), RW'(1));
    chk("t1_rd_data", rd_data, 64'h22222222_11111111);
    chk("t1_count", RW'(count), RW'(1));
    drain();

    // Fill to full with the reader stalled, then drain in order.
    for (int i = 1; i <= 16; i++) wr(W'(i), 0);
    chk("t2_full_count", RW'(count), RW'(8));
    chk("t2_full_ready", RW'(wr_ready), '0);
    wr_valid = 1;
    wr_data  = 32'd17;
    repeat (3) tick();
    wr_valid = 0;
    chk("t2_held_count", RW'(count), RW'(8));
    rd_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain_valid", RW'(rd_valid), RW'(1));
      chk("t2_drain_data", rd_data, {W'(2*k+2), W'(2*k+1)});
      tick();
    end
    chk("t2_empty_valid", RW'(rd_valid), '0);
    chk("t2_empty_count", RW'(count), '0);
    rd_ready = 0;

    // Continuous stream across several pointer wraps.
    maxc  = 0;
    pops0 = m_pops;
    rd_ready = 1;
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1;
      wr_data  = $urandom;
      tick();
      if (int'(count) > maxc) maxc = int'(count);
    end
    wr_valid = 0;
    repeat (4) tick();
    rd_ready = 0;
    chk("t3_max_count_le2", RW'(maxc <= 2), RW'(1));
    chk("t3_pops", RW'(m_pops - pops0), RW'(32));

    // Commit and pop in the same cycle leaves count unchanged.
    for (int i = 0; i < 6; i++) wr(32'hC0DE0000 + W'(i), 0);
    tick();
    chk("t4_count3", RW'(count), RW'(3));
    wr(32'hAAAA0001, 0);
    rd_ready = 1;
    wr(32'hAAAA0002, 0);
    rd_ready = 0;
    chk("t4_count_same", RW'(count), RW'(3));
    drain();

`ifdef ASYM_FIFO_FLUSH_EN
    // Flush a half-assembled word; the next write restarts at lane 0.
    wr(32'h0000000A, 1);
    tick();
    chk("flush_data", rd_data, 64'h00000000_0000000A);
    rd_ready = 1;
    tick();
    rd_ready = 0;
    wr(32'h0000000B, 0);
    wr(32'h0000000C, 0);
    tick();
    chk("flush_next_data", rd_data, 64'h0000000C_0000000B);
    drain();
`endif

    // Randomized traffic, including stray wr_last pulses.
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = $urandom;
      wr_last  = ($urandom_range(0, 7) == 0);
      rd_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    wr_valid = 0;
    wr_last  = 0;
    drain();

    // Reset in the middle of traffic: partial assembly must be discarded.
    wr(32'h00000001, 0);
    wr(32'h00000002, 0);
    wr(32'h00000003, 0);
    rst = 1;
    #1;
    chk("mid_rst_rd_valid", RW'(rd_valid), '0);
    chk("mid_rst_count", RW'(count), '0);
    tick();
    rst = 0;
    tick();
    wr(32'h00000005, 0);
    wr(32'h00000006, 0);
    tick();
    chk("post_rst_valid", RW'(rd_valid), RW'(1));
    chk("post_rst_data", rd_data, 64'h00000006_00000005);
    chk("post_rst_count", RW'(count), RW'(1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
